txt_line_fetch: RTL and testbench

Upstream feeder for the text-mode pixel generator. Fetches one 40-character Apple II text row from system memory over a req/ack handshake into a ping-pong line buffer. Serves characters to the renderer by column with fixed one-cycle latency. Computes the Apple II interleaved text-page address so the renderer only supplies a row number.

---
 rtl/txt_line_fetch.sv | 190 +++++++++++++++++++
 tb/tb_txt_line_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/txt_line_fetch.sv
// txt_line_fetch: fetches one 40-char Apple II text row into a ping-pong line buffer and serves it by column.
// Optional TXT_FLASH_EN builds the frame-driven flash timer for codes 40-7F. Revision 1.0.
`default_nettype none

module txt_line_fetch #(
   parameter logic [15:0] PAGE_BASE    = 16'h0400,
   parameter logic [15:0] FLASH_FRAMES = 16'd16
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        line_go,
   input  logic [4:0]  row,
   input  logic        frame,
   output logic        busy,
   output logic        line_ready,
   output logic        mem_req,
   output logic [15:0] mem_adr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_q,
   input  logic [5:0]  rd_col,
   output logic [7:0]  txt,
   output logic        inv
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        front_q, front_d;
   logic [4:0]  row_q, row_d;
   logic [5:0]  col_q, col_d;
   logic        mem_req_q, mem_req_d;
   logic [15:0] mem_adr_q, mem_adr_d;
   logic        busy_q, busy_d;
   logic        line_ready_q, line_ready_d;
   logic [7:0]  txt_q, txt_d;
   logic        inv_q, inv_d;
   logic        wr_en;
   logic        flash_inv;

   logic [7:0]  buf_a [0:39];
   logic [7:0]  buf_b [0:39];

   // Interleaved text page: 128 bytes per (row mod 8) group, 40 bytes per third of the screen.
   function automatic logic [15:0] txt_addr(input logic [4:0] r, input logic [5:0] c);
      return PAGE_BASE + {6'd0, r[2:0], 7'd0} + (16'(r[4:3]) * 16'd40) + {10'd0, c};
   endfunction

   always_comb begin
      state_d      = state_q;
      front_d      = front_q;
      row_d        = row_q;
      col_d        = col_q;
      mem_req_d    = mem_req_q;
      mem_adr_d    = mem_adr_q;
      line_ready_d = 1'b0;
      wr_en        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (line_go) begin
               front_d = ~front_q;
               row_d   = row;
               col_d   = 6'd0;
               if (row <= 5'd23) begin
                  state_d   = S_REQ;
                  mem_req_d = 1'b1;
                  mem_adr_d = txt_addr(row, 6'd0);
               end else begin
                  state_d      = S_DONE;
                  line_ready_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               wr_en = 1'b1;
               if (col_q == 6'd39) begin
                  state_d      = S_DONE;
                  mem_req_d    = 1'b0;
                  line_ready_d = 1'b1;
               end else begin
                  col_d     = col_q + 6'd1;
                  mem_adr_d = txt_addr(row_q, col_q + 6'd1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_comb begin
      txt_d = 8'hA0;
      if (rd_col < 6'd40) begin
         txt_d = front_q ? buf_b[rd_col] : buf_a[rd_col];
      end
      if (txt_d[7]) begin
         inv_d = 1'b0;
      end else if (!txt_d[6]) begin
         inv_d = 1'b1;
      end else begin
         inv_d = flash_inv;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         front_q      <= 1'b0;
         row_q        <= 5'd0;
         col_q        <= 6'd0;
         mem_req_q    <= 1'b0;
         mem_adr_q    <= 16'd0;
         busy_q       <= 1'b0;
         line_ready_q <= 1'b0;
         txt_q        <= 8'd0;
         inv_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         front_q      <= front_d;
         row_q        <= row_d;
         col_q        <= col_d;
         mem_req_q    <= mem_req_d;
         mem_adr_q    <= mem_adr_d;
         busy_q       <= busy_d;
         line_ready_q <= line_ready_d;
         txt_q        <= txt_d;
         inv_q        <= inv_d;
      end
   end

   // Fetch writes always land in the back buffer, so they never meet a read.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         if (front_q) begin
            buf_a[col_q] <= mem_q;
         end else begin
            buf_b[col_q] <= mem_q;
         end
      end
   end

`ifdef TXT_FLASH_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        flash_phase_q, flash_phase_d;

   always_comb begin
      frame_cnt_d   = frame_cnt_q;
      flash_phase_d = flash_phase_q;
      if (frame) begin
         if (frame_cnt_q >= FLASH_FRAMES - 16'd1) begin
            frame_cnt_d   = 16'd0;
            flash_phase_d = ~flash_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         frame_cnt_q   <= 16'd0;
         flash_phase_q <= 1'b0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         flash_phase_q <= flash_phase_d;
      end
   end

   assign flash_inv = flash_phase_q;
`else
   logic unused_flash;
   assign unused_flash = ^{frame, FLASH_FRAMES};
   assign flash_inv    = 1'b1;
`endif

   assign busy       = busy_q;
   assign line_ready = line_ready_q;
   assign mem_req    = mem_req_q;
   assign mem_adr    = mem_adr_q;
   assign txt        = txt_q;
   assign inv        = inv_q;

endmodule

`default_nettype wire

// File: tb/tb_txt_line_fetch.sv
// tb_txt_line_fetch: directed/randomized bench for txt_line_fetch against a row-level buffer model.
`default_nettype none

module tb_txt_line_fetch;

   localparam int FF = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        line_go = 1'b0;
   logic [4:0]  row = 5'd0;
   logic        frame = 1'b0;
   logic        busy, line_ready, mem_req, mem_ack, inv;
   logic [15:0] mem_adr;
   logic [7:0]  mem_q, txt;
   logic [5:0]  rd_col = 6'd0;

   logic [7:0]  mem_arr [0:65535];
   bit          use_addr = 1'b1;
   int          checks = 0;
   int          errors = 0;

   // Model state: two line buffers, which one is in front, frames since reset.
   logic [7:0]  exp_buf [0:1][0:39];
   int          exp_front = 0;
   int          frames = 0;

   always #5 clk = ~clk;

   assign mem_q = use_addr ? mem_adr[7:0] : mem_arr[mem_adr];

   txt_line_fetch #(.PAGE_BASE(16'h0400), .FLASH_FRAMES(16'(FF))) dut (
      .CLOCK_50(clk), .reset(reset), .line_go(line_go), .row(row), .frame(frame),
      .busy(busy), .line_ready(line_ready), .mem_req(mem_req), .mem_adr(mem_adr),
      .mem_ack(mem_ack), .mem_q(mem_q), .rd_col(rd_col), .txt(txt), .inv(inv)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_adr(input int r, input int c);
      return 16'(32'h400 + 128 * (r % 8) + 40 * (r / 8) + c);
   endfunction

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return use_addr ? a[7:0] : mem_arr[a];
   endfunction

   function automatic logic exp_inv(input logic [7:0] code);
      if (code >= 8'h80) return 1'b0;
      if (code < 8'h40) return 1'b1;
`ifdef TXT_FLASH_EN
      return 1'((frames / FF) % 2);
`else
      return 1'b1;
`endif
   endfunction

   // mode 0: zero-wait, 1: ack every 3rd cycle, 2: random acks. coll_col >= 0 injects a line_go.
   task automatic do_fetch(input int r, input int mode, input int coll_col);
      int col, cyc, back;
      bit ack, coll_done;
      logic [15:0] a;
      line_go = 1'b1;
      row = 5'(r);
      @(posedge clk); #1;
      line_go = 1'b0;
      exp_front = 1 - exp_front;
      back = 1 - exp_front;
      if (r >= 24) begin
         chk("oor_ready", {15'd0, line_ready}, 16'd1);
         chk("oor_req", {15'd0, mem_req}, 16'd0);
         chk("oor_busy", {15'd0, busy}, 16'd1);
         @(posedge clk); #1;
         chk("oor_idle", {15'd0, busy}, 16'd0);
         return;
      end
      col = 0;
      cyc = 0;
      coll_done = 1'b0;
      while (col < 40 && cyc < 400) begin
         a = exp_adr(r, col);
         chk("req", {15'd0, mem_req}, 16'd1);
         chk("adr", mem_adr, a);
         chk("busy", {15'd0, busy}, 16'd1);
         chk("ready_early", {15'd0, line_ready}, 16'd0);
         case (mode)
            0:       ack = 1'b1;
            1:       ack = (cyc % 3 == 2);
            default: ack = 1'($urandom_range(0, 1));
         endcase
         mem_ack = ack;
         if (col == coll_col && !coll_done) begin
            line_go = 1'b1;
            row = 5'((r + 5) % 24);
            coll_done = 1'b1;
         end
         @(posedge clk); #1;
         line_go = 1'b0;
         mem_ack = 1'b0;
         if (ack) begin
            exp_buf[back][col] = mem_val(a);
            col++;
         end
         cyc++;
      end
      chk("fetch_timeout", {15'd0, cyc < 400}, 16'd1);
      if (mode == 0) chk("zero_wait_cycles", 16'(cyc), 16'd40);
      chk("ready", {15'd0, line_ready}, 16'd1);
      chk("req_off", {15'd0, mem_req}, 16'd0);
      chk("busy_done", {15'd0, busy}, 16'd1);
      @(posedge clk); #1;
      chk("busy_fall", {15'd0, busy}, 16'd0);
      chk("ready_pulse", {15'd0, line_ready}, 16'd0);
   endtask

   task automatic read_col(input int c);
      logic [7:0] code;
      rd_col = 6'(c);
      @(posedge clk); #1;
      code = (c < 40) ? exp_buf[exp_front][c] : 8'hA0;
      chk("txt", {8'd0, txt}, {8'd0, code});
      chk("inv", {15'd0, inv}, {15'd0, exp_inv(code)});
   endtask

   task automatic check_reads();
      for (int c = 0; c < 40; c++) read_col(c);
      read_col(40);
      read_col(45);
      read_col(63);
      for (int k = 0; k < 10; k++) read_col(int'($urandom_range(0, 63)));
   endtask

   initial begin
      mem_ack = 1'b0;
      for (int i = 16'h400; i < 16'h800; i++) mem_arr[i] = 8'($urandom);

      // Reset values
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req", {15'd0, mem_req}, 16'd0);
      chk("rst_adr", mem_adr, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_ready", {15'd0, line_ready}, 16'd0);
      chk("rst_txt", {8'd0, txt}, 16'd0);
      chk("rst_inv", {15'd0, inv}, 16'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Zero-wait row 9 with address-echo memory, then a wait-state row 23
      do_fetch(9, 0, -1);
      use_addr = 1'b0;
      do_fetch(23, 1, -1);
      check_reads();

      // Out-of-range row: swap only, stale contents served
      do_fetch(24, 0, -1);
      check_reads();

      // Collision at column 10 with random acks
      do_fetch(int'($urandom_range(0, 23)), 2, 10);
      do_fetch(31, 0, -1);
      check_reads();

      // Async reset at column 20 of a fetch that started with front = A
      do_fetch(24, 0, -1);
      line_go = 1'b1;
      row = 5'd17;
      @(posedge clk); #1;
      line_go = 1'b0;
      exp_front = 1 - exp_front;
      mem_ack = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         exp_buf[1 - exp_front][c] = mem_val(exp_adr(17, c));
      end
      mem_ack = 1'b0;
      chk("pre_rst_req", {15'd0, mem_req}, 16'd1);
      #1 reset = 1'b0;
      #1;
      chk("async_req", {15'd0, mem_req}, 16'd0);
      chk("async_busy", {15'd0, busy}, 16'd0);
      exp_front = 0;
      frames = 0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", {15'd0, busy}, 16'd0);
      chk("post_rst_adr", mem_adr, 16'd0);
      check_reads();

      // Flash codes in row 0
      mem_arr[16'h400] = 8'h05;
      mem_arr[16'h401] = 8'h45;
      mem_arr[16'h402] = 8'hC5;
      do_fetch(0, 0, -1);
      do_fetch(24, 0, -1);
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 3; c++) read_col(c);
         frame = 1'b1;
         @(posedge clk); #1;
         frame = 1'b0;
         frames++;
      end
      read_col(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
